// File: rtl/unidade_oposto_vetorial.sv
// Streaming negate / abs / pass unit: processes one block of NUM_ELEM operands per start
// pulse through a single registered stage with valid/ready handshakes on both sides.
module unidade_oposto_vetorial #(
    parameter  int LARGURA  = 8,
    parameter  int NUM_ELEM = 25,
    localparam int CW       = $clog2(NUM_ELEM + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               iniciar,
    input  logic [1:0]         modo,
    input  logic [LARGURA-1:0] ent_dado,
    input  logic               ent_valido,
    output logic               ent_pronto,
    output logic [LARGURA:0]   sai_dado,
    output logic               sai_valido,
    input  logic               sai_pronto,
    output logic               ocupado,
    output logic               concluido,
    output logic [CW-1:0]      contador
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        PROCESSA  = 2'd1,
        CONCLUIDO = 2'd2
    } estado_t;

    localparam logic [CW-1:0] TOTAL = CW'(NUM_ELEM);

    estado_t          estado_q, estado_d;
    logic [1:0]       modo_q, modo_d;
    logic [CW-1:0]    aceitos_q, aceitos_d;
    logic [CW-1:0]    contador_q, contador_d;
    logic [LARGURA:0] dado_q, dado_d;
    logic             valido_q, valido_d;

    logic entrada_hs;
    logic saida_hs;

    // One extra bit of width makes every mode exact, including -0xFF and |-128|.
    function automatic logic [LARGURA:0] resultado(input logic [1:0] op,
                                                   input logic [LARGURA-1:0] x);
        logic [LARGURA:0] zext;
        logic [LARGURA:0] sext;
        zext = {1'b0, x};
        sext = {x[LARGURA-1], x};
        case (op)
            2'b00:   return -zext;
            2'b01:   return -sext;
            2'b10:   return x[LARGURA-1] ? -sext : sext;
            default: return sext;
        endcase
    endfunction

    // A new operand may enter only if the output slot is empty or is being drained now.
    assign ent_pronto = (estado_q == PROCESSA) && (aceitos_q < TOTAL)
                        && (!valido_q || sai_pronto);
    assign entrada_hs = ent_valido && ent_pronto;
    assign saida_hs   = valido_q && sai_pronto;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        estado_d   = estado_q;
        modo_d     = modo_q;
        aceitos_d  = aceitos_q;
        contador_d = contador_q;
        dado_d     = dado_q;
        valido_d   = valido_q;

        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    estado_d   = PROCESSA;
                    modo_d     = modo;
                    aceitos_d  = '0;
                    contador_d = '0;
                end
            end
            PROCESSA: begin
                if (entrada_hs) begin
                    dado_d    = resultado(modo_q, ent_dado);
                    aceitos_d = aceitos_q + CW'(1);
                    valido_d  = 1'b1;
                end else if (saida_hs) begin
                    valido_d  = 1'b0;
                end
                if (saida_hs) begin
                    contador_d = contador_q + CW'(1);
                    if (contador_q == TOTAL - CW'(1)) begin
                        estado_d = CONCLUIDO;
                    end
                end
            end
            CONCLUIDO: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            estado_q   <= OCIOSO;
            modo_q     <= 2'b00;
            aceitos_q  <= '0;
            contador_q <= '0;
            dado_q     <= '0;
            valido_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            modo_q     <= modo_d;
            aceitos_q  <= aceitos_d;
            contador_q <= contador_d;
            dado_q     <= dado_d;
            valido_q   <= valido_d;
        end
    end

    assign sai_dado   = dado_q;
    assign sai_valido = valido_q;
    assign ocupado    = (estado_q == PROCESSA);
    assign concluido  = (estado_q == CONCLUIDO);
    assign contador   = contador_q;

endmodule
